// File: rtl/axil_pkg.sv
// Shared types and constants for the AXI4-Lite 2:1 memory arbiter.
// Holds the FSM state encodings, the response codes and a grant-index helper.
package axil_pkg;

    typedef enum logic [1:0] {
        RD_IDLE = 2'd0,
        RD_ADDR = 2'd1,
        RD_DATA = 2'd2
    } rd_state_e;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_REQ  = 2'd1,
        WR_RESP = 2'd2
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // One-hot grant to port index: 0 selects S0, 1 selects S1.
    function automatic logic onehot_to_idx(input logic [1:0] oh);
        return (oh == 2'b10);
    endfunction

endpackage

// File: rtl/axil_rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the port that was not granted last wins.
// The last-grant register starts at S1 so that S0 wins the first tie.
module axil_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    logic last_q;
    logic last_d;

    // Grant selection from current requests and the last winner.
    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = last_q ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

    // Next value of the last-grant register.
    always_comb begin
        last_d = last_q;
        if (advance_i && (gnt_o != 2'b00)) begin
            last_d = gnt_o[1];
        end else begin
            last_d = last_q;
        end
    end

    // Last-grant register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/axil_mem_arbiter.sv
// 2:1 AXI4-Lite arbiter sharing one memory slave between the instruction (S0) and data (S1) masters.
// Read and write paths are arbitrated independently, one outstanding transaction each.
module axil_mem_arbiter
    import axil_pkg::*;
#(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s0_awaddr,
    input  logic              s0_awvalid,
    output logic              s0_awready,
    input  logic [DATA_W-1:0] s0_wdata,
    input  logic [STRB_W-1:0] s0_wstrb,
    input  logic              s0_wvalid,
    output logic              s0_wready,
    output logic [1:0]        s0_bresp,
    output logic              s0_bvalid,
    input  logic              s0_bready,
    input  logic [ADDR_W-1:0] s0_araddr,
    input  logic              s0_arvalid,
    output logic              s0_arready,
    output logic [DATA_W-1:0] s0_rdata,
    output logic [1:0]        s0_rresp,
    output logic              s0_rvalid,
    input  logic              s0_rready,
    input  logic [ADDR_W-1:0] s1_awaddr,
    input  logic              s1_awvalid,
    output logic              s1_awready,
    input  logic [DATA_W-1:0] s1_wdata,
    input  logic [STRB_W-1:0] s1_wstrb,
    input  logic              s1_wvalid,
    output logic              s1_wready,
    output logic [1:0]        s1_bresp,
    output logic              s1_bvalid,
    input  logic              s1_bready,
    input  logic [ADDR_W-1:0] s1_araddr,
    input  logic              s1_arvalid,
    output logic              s1_arready,
    output logic [DATA_W-1:0] s1_rdata,
    output logic [1:0]        s1_rresp,
    output logic              s1_rvalid,
    input  logic              s1_rready,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [DATA_W-1:0] m_wdata,
    output logic [STRB_W-1:0] m_wstrb,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rvalid,
    output logic              m_rready
);

    rd_state_e rd_state_q, rd_state_d;
    wr_state_e wr_state_q, wr_state_d;
    logic      rd_gnt_q, rd_gnt_d;
    logic      wr_gnt_q, wr_gnt_d;
    logic      aw_done_q, aw_done_d;
    logic      w_done_q, w_done_d;
    logic      rd_adv_s, wr_adv_s;
    logic [1:0] rd_req_s, wr_req_s, rd_arb_gnt_s, wr_arb_gnt_s;

    assign rd_req_s = {s1_arvalid, s0_arvalid};
    // Write arbitration looks at awvalid only; a lone wvalid never wins.
    assign wr_req_s = {s1_awvalid, s0_awvalid};

    axil_rr_arb2 u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rd_req_s),
        .advance_i (rd_adv_s),
        .gnt_o     (rd_arb_gnt_s)
    );

    axil_rr_arb2 u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (wr_req_s),
        .advance_i (wr_adv_s),
        .gnt_o     (wr_arb_gnt_s)
    );

    // State, grant and handshake-flag registers for both paths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            rd_gnt_q   <= 1'b0;
            wr_gnt_q   <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
        end
    end

    // Read FSM next state; the grant is only latched in RD_IDLE.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rd_adv_s   = 1'b0;
        case (rd_state_q)
            RD_IDLE: begin
                if (|rd_req_s) begin
                    rd_adv_s   = 1'b1;
                    rd_gnt_d   = onehot_to_idx(rd_arb_gnt_s);
                    rd_state_d = RD_ADDR;
                end else begin
                    rd_state_d = RD_IDLE;
                end
            end
            RD_ADDR: begin
                if (m_arvalid && m_arready) begin
                    rd_state_d = RD_DATA;
                end else begin
                    rd_state_d = RD_ADDR;
                end
            end
            RD_DATA: begin
                if (m_rvalid && m_rready) begin
                    rd_state_d = RD_IDLE;
                end else begin
                    rd_state_d = RD_DATA;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Read channel muxes; the non-granted port sees valid/ready low and zero data.
    always_comb begin
        m_araddr   = '0;
        m_arvalid  = 1'b0;
        m_rready   = 1'b0;
        s0_arready = 1'b0;
        s1_arready = 1'b0;
        s0_rdata   = '0;
        s0_rresp   = RESP_OKAY;
        s0_rvalid  = 1'b0;
        s1_rdata   = '0;
        s1_rresp   = RESP_OKAY;
        s1_rvalid  = 1'b0;
        if (rd_state_q == RD_ADDR) begin
            m_araddr   = rd_gnt_q ? s1_araddr : s0_araddr;
            m_arvalid  = rd_gnt_q ? s1_arvalid : s0_arvalid;
            s0_arready = !rd_gnt_q && m_arready;
            s1_arready = rd_gnt_q && m_arready;
        end else if (rd_state_q == RD_DATA) begin
            m_rready = rd_gnt_q ? s1_rready : s0_rready;
            if (rd_gnt_q) begin
                s1_rdata  = m_rdata;
                s1_rresp  = m_rresp;
                s1_rvalid = m_rvalid;
            end else begin
                s0_rdata  = m_rdata;
                s0_rresp  = m_rresp;
                s0_rvalid = m_rvalid;
            end
        end else begin
            m_arvalid = 1'b0;
        end
    end

    // Write FSM next state; aw and w may complete in either order or together.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        wr_adv_s   = 1'b0;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        case (wr_state_q)
            WR_IDLE: begin
                if (|wr_req_s) begin
                    wr_adv_s   = 1'b1;
                    wr_gnt_d   = onehot_to_idx(wr_arb_gnt_s);
                    wr_state_d = WR_REQ;
                end else begin
                    wr_state_d = WR_IDLE;
                end
            end
            WR_REQ: begin
                aw_done_d = aw_done_q | (m_awvalid & m_awready);
                w_done_d  = w_done_q | (m_wvalid & m_wready);
                if (aw_done_d && w_done_d) begin
                    wr_state_d = WR_RESP;
                    aw_done_d  = 1'b0;
                    w_done_d   = 1'b0;
                end else begin
                    wr_state_d = WR_REQ;
                end
            end
            WR_RESP: begin
                if (m_bvalid && m_bready) begin
                    wr_state_d = WR_IDLE;
                end else begin
                    wr_state_d = WR_RESP;
                end
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    // Write channel muxes; a completed aw or w handshake masks that channel.
    always_comb begin
        m_awaddr   = '0;
        m_awvalid  = 1'b0;
        m_wdata    = '0;
        m_wstrb    = '0;
        m_wvalid   = 1'b0;
        m_bready   = 1'b0;
        s0_awready = 1'b0;
        s1_awready = 1'b0;
        s0_wready  = 1'b0;
        s1_wready  = 1'b0;
        s0_bresp   = RESP_OKAY;
        s0_bvalid  = 1'b0;
        s1_bresp   = RESP_OKAY;
        s1_bvalid  = 1'b0;
        if (wr_state_q == WR_REQ) begin
            m_awaddr   = wr_gnt_q ? s1_awaddr : s0_awaddr;
            m_awvalid  = (wr_gnt_q ? s1_awvalid : s0_awvalid) && !aw_done_q;
            m_wdata    = wr_gnt_q ? s1_wdata : s0_wdata;
            m_wstrb    = wr_gnt_q ? s1_wstrb : s0_wstrb;
            m_wvalid   = (wr_gnt_q ? s1_wvalid : s0_wvalid) && !w_done_q;
            s0_awready = !wr_gnt_q && m_awready && !aw_done_q;
            s1_awready = wr_gnt_q && m_awready && !aw_done_q;
            s0_wready  = !wr_gnt_q && m_wready && !w_done_q;
            s1_wready  = wr_gnt_q && m_wready && !w_done_q;
        end else if (wr_state_q == WR_RESP) begin
            m_bready = wr_gnt_q ? s1_bready : s0_bready;
            if (wr_gnt_q) begin
                s1_bresp  = m_bresp;
                s1_bvalid = m_bvalid;
            end else begin
                s0_bresp  = m_bresp;
                s0_bvalid = m_bvalid;
            end
        end else begin
            m_awvalid = 1'b0;
        end
    end

endmodule

// File: tb/tb_axil_mem_arbiter.sv
// Self-checking bench for axil_mem_arbiter: two master drivers, a reactive memory model
// and per-port scoreboards of expected read data and write responses.
module tb_axil_mem_arbiter;
    import axil_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0][31:0] awaddr = '0, wdata = '0, araddr = '0;
    logic [1:0][3:0]  wstrb = '0;
    logic [1:0]       awvalid = '0, wvalid = '0, bready = '0, arvalid = '0, rready = '0;
    wire  [1:0]       awready, wready, bvalid, arready, rvalid;
    wire  [1:0][1:0]  bresp, rresp;
    wire  [1:0][31:0] rdata;

    wire [31:0] m_awaddr, m_wdata, m_araddr;
    wire [3:0]  m_wstrb;
    wire        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    wire        m_awready, m_wready, m_arready;
    logic [1:0]  m_bresp = '0, m_rresp = '0;
    logic        m_bvalid = 1'b0, m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;

    logic wready_stall = 1'b0;
    int   checks = 0;
    int   failures = 0;
    int   wr_count = 0;
    int   order_q[$];
    logic [33:0] exp_rd0[$], exp_rd1[$];
    logic [1:0]  exp_b0[$], exp_b1[$];
    logic [31:0] ref_mem [256];

    axil_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .s0_awaddr(awaddr[0]), .s0_awvalid(awvalid[0]), .s0_awready(awready[0]),
        .s0_wdata(wdata[0]), .s0_wstrb(wstrb[0]), .s0_wvalid(wvalid[0]), .s0_wready(wready[0]),
        .s0_bresp(bresp[0]), .s0_bvalid(bvalid[0]), .s0_bready(bready[0]),
        .s0_araddr(araddr[0]), .s0_arvalid(arvalid[0]), .s0_arready(arready[0]),
        .s0_rdata(rdata[0]), .s0_rresp(rresp[0]), .s0_rvalid(rvalid[0]), .s0_rready(rready[0]),
        .s1_awaddr(awaddr[1]), .s1_awvalid(awvalid[1]), .s1_awready(awready[1]),
        .s1_wdata(wdata[1]), .s1_wstrb(wstrb[1]), .s1_wvalid(wvalid[1]), .s1_wready(wready[1]),
        .s1_bresp(bresp[1]), .s1_bvalid(bvalid[1]), .s1_bready(bready[1]),
        .s1_araddr(araddr[1]), .s1_arvalid(arvalid[1]), .s1_arready(arready[1]),
        .s1_rdata(rdata[1]), .s1_rresp(rresp[1]), .s1_rvalid(rvalid[1]), .s1_rready(rready[1]),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h00a00093 : {8'h5a, 8'(i), 8'(i ^ 255), 8'h11};
    endfunction

    // Memory model: 256 words, 1-cycle read latency, SLVERR above 0x3FF.
    logic [31:0] mem [256];
    logic        mem_aw_got = 1'b0, mem_w_got = 1'b0;
    logic [31:0] mem_awaddr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    assign m_arready = ~rst;
    assign m_awready = ~rst;
    assign m_wready  = ~rst & ~wready_stall;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            m_rvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0;
            m_bvalid <= 1'b0; m_bresp <= '0;
            mem_aw_got <= 1'b0; mem_w_got <= 1'b0;
        end else begin
            if (m_rvalid && m_rready) m_rvalid <= 1'b0;
            if (m_arvalid && m_arready) begin
                m_rvalid <= 1'b1;
                m_rdata  <= (m_araddr[31:10] != 22'd0) ? 32'd0 : mem[m_araddr[9:2]];
                m_rresp  <= (m_araddr[31:10] != 22'd0) ? RESP_SLVERR : RESP_OKAY;
            end
            if (m_awvalid && m_awready) begin mem_aw_got <= 1'b1; mem_awaddr <= m_awaddr; end
            if (m_wvalid && m_wready) begin
                mem_w_got <= 1'b1; mem_wdata <= m_wdata; mem_wstrb <= m_wstrb;
            end
            if (mem_aw_got && mem_w_got) begin
                mem_aw_got <= 1'b0; mem_w_got <= 1'b0;
                m_bvalid <= 1'b1;
                wr_count <= wr_count + 1;
                if (mem_awaddr[31:10] != 22'd0) begin
                    m_bresp <= RESP_SLVERR;
                end else begin
                    m_bresp <= RESP_OKAY;
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_awaddr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
            if (m_bvalid && m_bready) m_bvalid <= 1'b0;
        end
    end

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    endtask

    // Read on port p; returns cycles from arvalid to the address handshake cycle.
    task automatic do_read(input int p, input logic [31:0] addr, input int rdy_delay, output int ar_wait);
        logic [33:0] exp, got;
        int n;
        exp = (addr[31:10] != 22'd0) ? {RESP_SLVERR, 32'd0} : {RESP_OKAY, ref_mem[addr[9:2]]};
        if (p == 0) exp_rd0.push_back(exp); else exp_rd1.push_back(exp);
        araddr[p] = addr; arvalid[p] = 1'b1; n = 0;
        #1;
        while (!arready[p] && n < 100) begin @(negedge clk); #1; n++; end
        ar_wait = n;
        checks++;
        if (!arready[p]) begin
            failures++; $display("FAIL ar_timeout p%0d: arready=%b required 1", p, arready[p]);
            @(negedge clk); arvalid[p] = 1'b0; return;
        end
        checks++;
        if (m_araddr !== addr) begin
            failures++; $display("FAIL m_araddr p%0d: got %h required %h", p, m_araddr, addr);
        end
        @(negedge clk); arvalid[p] = 1'b0; rready[p] = 1'b0; n = 0;
        #1;
        while (!rvalid[p] && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (!rvalid[p]) begin
            failures++; $display("FAIL r_timeout p%0d: rvalid=%b required 1", p, rvalid[p]); return;
        end
        checks++;
        if (rvalid[1-p] !== 1'b0) begin
            failures++; $display("FAIL r_cross p%0d: other rvalid=%b required 0", p, rvalid[1-p]);
        end
        for (int i = 0; i < rdy_delay; i++) begin
            checks++;
            if (m_rready !== 1'b0 || rdata[p] !== exp[31:0] || rvalid[p] !== 1'b1) begin
                failures++;
                $display("FAIL r_hold p%0d: m_rready=%b rdata=%h rvalid=%b required 0/%h/1",
                         p, m_rready, rdata[p], rvalid[p], exp[31:0]);
            end
            @(negedge clk); #1;
        end
        rready[p] = 1'b1;
        #1;
        got = {rresp[p], rdata[p]};
        exp = (p == 0) ? exp_rd0.pop_front() : exp_rd1.pop_front();
        checks++;
        if (got !== exp || m_rready !== 1'b1) begin
            failures++;
            $display("FAIL rdata p%0d: got resp/data %h m_rready=%b required %h/1", p, got, m_rready, exp);
        end
        order_q.push_back(p);
        @(negedge clk); rready[p] = 1'b0;
    endtask

    // Write on port p; wvalid is raised w_lead cycles ahead of awvalid.
    task automatic do_write(input int p, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int w_lead);
        logic a, w, aw_done, w_done;
        logic [1:0] exp;
        int n, wc0;
        exp = (addr[31:10] != 22'd0) ? RESP_SLVERR : RESP_OKAY;
        if (p == 0) exp_b0.push_back(exp); else exp_b1.push_back(exp);
        if (addr[31:10] == 22'd0)
            for (int b = 0; b < 4; b++)
                if (strb[b]) ref_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
        wc0 = wr_count;
        awaddr[p] = addr; wdata[p] = data; wstrb[p] = strb; wvalid[p] = 1'b1;
        for (int i = 0; i < w_lead; i++) begin
            #1;
            checks++;
            if (wready[p] !== 1'b0 || m_wvalid !== 1'b0) begin
                failures++;
                $display("FAIL w_only_grant p%0d: wready=%b m_wvalid=%b required 0/0", p, wready[p], m_wvalid);
            end
            @(negedge clk);
        end
        awvalid[p] = 1'b1; aw_done = 1'b0; w_done = 1'b0; n = 0;
        while (!(aw_done && w_done) && n < 100) begin
            #1;
            a = awvalid[p] && awready[p];
            w = wvalid[p] && wready[p];
            @(negedge clk);
            if (a) begin awvalid[p] = 1'b0; aw_done = 1'b1; end
            if (w) begin wvalid[p] = 1'b0; w_done = 1'b1; end
            n++;
        end
        checks++;
        if (!(aw_done && w_done)) begin
            failures++; $display("FAIL aw_w_timeout p%0d: aw_done=%b w_done=%b required 1/1", p, aw_done, w_done);
            awvalid[p] = 1'b0; wvalid[p] = 1'b0; return;
        end
        bready[p] = 1'b1; n = 0;
        #1;
        while (!bvalid[p] && n < 100) begin @(negedge clk); #1; n++; end
        checks++;
        if (!bvalid[p]) begin
            failures++; $display("FAIL b_timeout p%0d: bvalid=%b required 1", p, bvalid[p]);
            bready[p] = 1'b0; return;
        end
        exp = (p == 0) ? exp_b0.pop_front() : exp_b1.pop_front();
        checks++;
        if (bresp[p] !== exp || bvalid[1-p] !== 1'b0) begin
            failures++;
            $display("FAIL bresp p%0d: got %b other bvalid=%b required %b/0", p, bresp[p], bvalid[1-p], exp);
        end
        @(negedge clk); bready[p] = 1'b0;
        #1;
        checks++;
        if (bvalid[p] !== 1'b0 || wr_count != wc0 + 1) begin
            failures++;
            $display("FAIL b_once p%0d: bvalid=%b writes=%0d required 0/%0d", p, bvalid[p], wr_count - wc0, 1);
        end
    endtask

    task automatic test_reset();
        ref_init();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 5'b0 ||
            {arready, rvalid, awready, wready, bvalid} !== 10'b0 || rdata !== 64'd0 || m_araddr !== 32'd0) begin
            failures++;
            $display("FAIL reset_outputs: m=%b s=%b rdata=%h required all zero",
                     {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready},
                     {arready, rvalid, awready, wready, bvalid}, rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read_basic();
        int w;
        do_read(0, 32'h0, 0, w);
        checks++;
        if (w != 1) begin failures++; $display("FAIL ar_latency: got %0d cycles required 1", w); end
        do_read(1, 32'h800, 0, w);
    endtask

    task automatic test_round_robin();
        int w0, w1, w2;
        order_q.delete();
        fork
            do_read(0, 32'h0, 0, w0);
            do_read(1, 32'h64, 0, w1);
        join
        checks++;
        if (order_q.size() != 2 || order_q[0] != 0 || order_q[1] != 1) begin
            failures++; $display("FAIL rr_first_tie: got order %p required S0 then S1", order_q);
        end
        do_read(0, 32'h8, 0, w2);
        order_q.delete();
        fork
            do_read(0, 32'h0, 0, w0);
            do_read(1, 32'h64, 0, w1);
        join
        checks++;
        if (order_q.size() != 2 || order_q[0] != 1 || order_q[1] != 0) begin
            failures++; $display("FAIL rr_second_tie: got order %p required S1 then S0", order_q);
        end
    endtask

    task automatic test_write();
        int w;
        do_write(1, 32'h64, 32'd30, 4'hF, 0);
        checks++;
        if (mem[25] !== 32'd30) begin failures++; $display("FAIL mem25: got %h required %h", mem[25], 32'd30); end
        do_write(1, 32'h104, 32'hAABBCCDD, 4'b0101, 0);
        do_read(0, 32'h104, 0, w);
        do_write(1, 32'h68, 32'h12345678, 4'hF, 2);
        do_write(0, 32'h900, 32'h1, 4'hF, 0);
    endtask

    task automatic test_write_order();
        fork
            do_write(0, 32'h70, 32'hCAFE0001, 4'hF, 0);
            begin
                wready_stall = 1'b1;
                repeat (2) @(negedge clk);
                #1;
                checks++;
                if (m_awvalid !== 1'b0 || m_wvalid !== 1'b1) begin
                    failures++;
                    $display("FAIL aw_masked: m_awvalid=%b m_wvalid=%b required 0/1", m_awvalid, m_wvalid);
                end
                @(negedge clk); wready_stall = 1'b0;
            end
        join
    endtask

    task automatic test_concurrent();
        int w;
        logic overlap = 1'b0;
        fork
            begin
                do_read(0, 32'h8, 0, w);
                do_read(0, 32'hC, 0, w);
                do_read(0, 32'h10, 0, w);
            end
            do_write(1, 32'h100, 32'hDEADBEEF, 4'hF, 0);
            repeat (20) begin
                @(negedge clk); #1;
                if ((m_arvalid || m_rready) && (m_awvalid || m_wvalid || m_bready)) overlap = 1'b1;
            end
        join
        checks++;
        if (overlap !== 1'b1 || mem[64] !== 32'hDEADBEEF) begin
            failures++; $display("FAIL overlap: overlap=%b mem64=%h required 1/deadbeef", overlap, mem[64]);
        end
    endtask

    task automatic test_rready_stall();
        int w;
        do_read(0, 32'h14, 3, w);
    endtask

    task automatic test_reset_midflight();
        int n, w;
        araddr[0] = 32'h10; arvalid[0] = 1'b1; rready[0] = 1'b0; n = 0;
        #1;
        while (!rvalid[0] && n < 100) begin
            @(negedge clk);
            if (!m_arvalid) arvalid[0] = 1'b0;
            #1; n++;
        end
        arvalid[0] = 1'b0;
        checks++;
        if (rvalid[0] !== 1'b1) begin failures++; $display("FAIL midflight_rvalid: got %b required 1", rvalid[0]); end
        rst = 1'b1;
        #1;
        checks++;
        if ({m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready} !== 5'b0 ||
            {arready, rvalid, awready, wready, bvalid} !== 10'b0 || rdata[0] !== 32'd0) begin
            failures++;
            $display("FAIL midflight_reset: m=%b s=%b rdata0=%h required all zero",
                     {m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready},
                     {arready, rvalid, awready, wready, bvalid}, rdata[0]);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_init();
        @(negedge clk);
        do_read(0, 32'h4, 0, w);
    endtask

    initial begin
        test_reset();
        test_read_basic();
        test_round_robin();
        test_write();
        test_write_order();
        test_concurrent();
        test_rready_stall();
        test_reset_midflight();
        checks++;
        if (exp_rd0.size() + exp_rd1.size() + exp_b0.size() + exp_b1.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_empty: %0d entries left required 0",
                     exp_rd0.size() + exp_rd1.size() + exp_b0.size() + exp_b1.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
